// File: rtl/vga_frame_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_fetcher_pkg
// Summary  : Shared state encoding and constants for the VGA frame fetcher.
// Revision : 1.0 - initial release
// ============================================================================
package vga_frame_fetcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_REQ   = 2'd2,
      ST_DATA  = 2'd3
   } fetch_state_t;

   localparam int c_FIFO_DEPTH   = 64;
   localparam int c_DEF_H_RES    = 640;
   localparam int c_DEF_V_RES    = 480;
   localparam int c_FRAME_PIXELS = c_DEF_H_RES * c_DEF_V_RES;

   function automatic int frame_pixels(input int h_res, input int v_res);
      return h_res * v_res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_fetcher_vsync_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : vsync_edge_sync
// Summary  : 2-flop synchronizer for the raw VGA vsync plus falling-edge
//            detect; only built when FETCH_VSYNC_RESYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef FETCH_VSYNC_RESYNC_EN
module vsync_edge_sync (
   input  logic clk75,
   input  logic reset,
   input  logic vs_async,
   output logic vs_fall
);

   logic [1:0] r_sync;
   logic       r_prev;

   // Idle-high reset so releasing reset never looks like a falling edge.
   always_ff @(posedge clk75 or negedge reset) begin
      if (!reset) begin
         r_sync <= 2'b11;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], vs_async};
         r_prev <= r_sync[1];
      end
   end

   assign vs_fall = r_prev & ~r_sync[1];

endmodule
`endif
`default_nettype wire

// File: rtl/vga_frame_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_fetcher
// Summary  : Burst-reads the framebuffer from SDRAM and feeds the VGA pixel
//            FIFO. Optional vsync resync: FETCH_VSYNC_RESYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_fetcher
   import vga_frame_fetcher_pkg::*;
#(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int BURST_LEN   = 8,
   parameter int ADDR_W      = 22,
   parameter int BASE_ADDR   = 0,
   parameter int FIFO_MARGIN = 2
) (
   input  logic              clk75,
   input  logic              reset,
`ifdef FETCH_VSYNC_RESYNC_EN
   input  logic              vga_vs,
`endif
   input  logic              enable,
   input  logic [6:0]        freeslots,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic              rd_valid,
   input  logic [31:0]       rd_data,
   output logic              wr_en,
   output logic [23:0]       data_bgr,
   output logic              frame_done,
   output logic              overrun
);

   localparam int              c_FRAME     = frame_pixels(H_RES, V_RES);
   localparam int              c_PIX_W     = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;
   localparam int              c_BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [c_PIX_W-1:0]  c_PIX_LAST  = c_PIX_W'(c_FRAME - BURST_LEN);
   localparam logic [c_PIX_W-1:0]  c_PIX_STEP  = c_PIX_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0]   c_ADDR_STEP = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0]   c_BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST_LEN - 1);
   localparam logic [7:0]          c_THRESH    = 8'(BURST_LEN + FIFO_MARGIN);

   fetch_state_t        r_state;
   fetch_state_t        w_state_nxt;
   logic [c_PIX_W-1:0]  r_pix;
   logic [c_BEAT_W-1:0] r_beat;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_rd_req;
   logic                r_wr_en;
   logic [23:0]         r_data;
   logic                r_frame_done;
   logic                r_overrun;

   logic w_slots_ok;
   logic w_in_data;
   logic w_last_beat;
   logic w_frame_end;
   logic w_enter_check;
   logic w_resync_now;
   logic w_unused_hi;

   assign w_unused_hi   = ^rd_data[31:24];
   assign w_slots_ok    = {1'b0, freeslots} >= c_THRESH;
   assign w_in_data     = (r_state == ST_DATA);
   assign w_last_beat   = w_in_data && rd_valid && (r_beat == c_BEAT_LAST);
   assign w_frame_end   = w_last_beat && (r_pix == c_PIX_LAST);
   assign w_enter_check = (w_state_nxt == ST_CHECK) && (r_state != ST_CHECK);

`ifdef FETCH_VSYNC_RESYNC_EN
   logic w_vs_fall;
   logic r_resync_pend;

   vsync_edge_sync u_vsync_edge_sync (
      .clk75    (clk75),
      .reset    (reset),
      .vs_async (vga_vs),
      .vs_fall  (w_vs_fall)
   );

   // A fall coinciding with CHECK entry is consumed immediately.
   assign w_resync_now = w_enter_check && (r_resync_pend || w_vs_fall);

   always_ff @(posedge clk75 or negedge reset) begin
      if (!reset) begin
         r_resync_pend <= 1'b0;
      end else begin
         r_resync_pend <= (r_resync_pend || w_vs_fall) && !w_resync_now;
      end
   end
`else
   assign w_resync_now = 1'b0;
`endif

   always_ff @(posedge clk75 or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (!enable)         w_state_nxt = ST_IDLE;
            else if (w_slots_ok) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (rd_ack) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_last_beat) w_state_nxt = enable ? ST_CHECK : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk75 or negedge reset) begin
      if (!reset) begin
         r_rd_req     <= 1'b0;
         r_addr       <= c_BASE;
         r_pix        <= '0;
         r_beat       <= '0;
         r_wr_en      <= 1'b0;
         r_data       <= 24'd0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_wr_en      <= w_in_data && rd_valid;
         r_frame_done <= w_frame_end;

         if (w_in_data && rd_valid) r_data <= rd_data[23:0];

         // Beats arriving with no burst in flight are dropped and flagged.
         if (rd_valid && !w_in_data) r_overrun <= 1'b1;

         if (r_state == ST_CHECK && w_state_nxt == ST_REQ) r_rd_req <= 1'b1;
         else if (r_state == ST_REQ && rd_ack)             r_rd_req <= 1'b0;

         if (r_state == ST_REQ && rd_ack)  r_beat <= '0;
         else if (w_in_data && rd_valid)   r_beat <= r_beat + 1'b1;

         if (w_resync_now) begin
            r_addr <= c_BASE;
            r_pix  <= '0;
         end else if (w_frame_end) begin
            r_addr <= c_BASE;
            r_pix  <= '0;
         end else if (w_last_beat) begin
            r_addr <= r_addr + c_ADDR_STEP;
            r_pix  <= r_pix + c_PIX_STEP;
         end
      end
   end

   assign rd_req     = r_rd_req;
   assign rd_addr    = r_addr;
   assign wr_en      = r_wr_en;
   assign data_bgr   = r_data;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/vga_frame_fetcher.md
Name: vga_frame_fetcher

Overview:
- SDRAM-side producer for the VGA pixel FIFO, running in the clk75 domain.
- Issues fixed-length burst reads of the framebuffer to the SDRAM controller and forwards returned pixels as wr_en/data_bgr into the VGA module.
- Throttles on the FIFO's freeslots count so the FIFO never overflows, and walks the framebuffer linearly, wrapping at end of frame.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- BURST_LEN, 8, pixels per SDRAM read burst; H_RES*V_RES must be a multiple of it.
- ADDR_W, 22, SDRAM word-address width.
- BASE_ADDR, 0, framebuffer start word address.
- FIFO_MARGIN, 2, extra free slots required beyond BURST_LEN before a request is issued.

Ports:
- clk75 input 1: system/SDRAM clock; all logic on its rising edge.
- reset input 1: asynchronous, active-low reset.
- enable input 1: level; 1 allows fetching.
- freeslots input 7: free FIFO entries (0..64) from the VGA module.
- rd_req output 1: burst read request to the SDRAM controller.
- rd_addr output ADDR_W: start word address of the requested burst.
- rd_ack input 1: one-cycle pulse; the controller accepted the request.
- rd_valid input 1: one returned data word per cycle when high.
- rd_data input 32: returned word; pixel is in [23:0], B in [23:16], G in [15:8], R in [7:0].
- wr_en output 1: FIFO write strobe.
- data_bgr output 24: pixel to the FIFO.
- frame_done output 1: one-cycle pulse when the last burst of a frame completes.
- overrun output 1: sticky error flag.

Behaviour:
- Reset values: rd_req=0, rd_addr=BASE_ADDR, wr_en=0, data_bgr=0, frame_done=0, overrun=0, state=IDLE, pixel counter=0, beat counter=0.
- FSM, 4 states:
  - IDLE: go to CHECK when enable=1.
  - CHECK:
    - If enable=0, go to IDLE.
    - Else if freeslots >= BURST_LEN+FIFO_MARGIN (compare unsigned at 8 bits), set rd_req=1 and go to REQ.
    - Otherwise stay in CHECK.
  - REQ:
    - Hold rd_req=1 and rd_addr stable until rd_ack=1.
    - On rd_ack, drop rd_req on the next edge, clear the beat counter and go to DATA.
    - enable=0 while in REQ is ignored; the request completes.
  - DATA:
    - Each rd_valid cycle increments the beat counter.
    - After the BURST_LEN-th beat, advance rd_addr and the pixel counter by BURST_LEN, then go to CHECK (or IDLE if enable=0).
- Forwarding:
  - wr_en and data_bgr are registered from rd_valid and rd_data[23:0], giving exactly 1 cycle latency.
  - Forwarding is active only in DATA.
  - Back-to-back beats yield back-to-back writes.
- Stray data: rd_valid outside DATA is dropped, not forwarded, and sets overrun=1. overrun clears only on reset.
- End of frame:
  - When the pixel counter reaches H_RES*V_RES-BURST_LEN and that burst completes, rd_addr wraps to BASE_ADDR and the pixel counter to 0.
  - frame_done pulses for 1 cycle, coincident with the state change out of DATA.
- At most one burst is outstanding. The margin check guarantees the FIFO cannot overflow despite the 1-cycle write latency.
- Reset mid-burst returns the block to IDLE immediately. The SDRAM controller shares this reset, so no in-flight beats survive.
- The pixel counter is sized as ceil(log2(H_RES*V_RES)) bits. rd_addr arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: FETCH_VSYNC_RESYNC_EN.
- When defined:
  - Adds input vga_vs: raw VGA vertical sync from the 25 MHz domain.
  - vga_vs passes through a 2-flop synchronizer into clk75.
  - A falling edge sets a pending-resync flag.
  - At the next CHECK entry, rd_addr is forced to BASE_ADDR and the pixel counter to 0; frame_done is not pulsed; the flag then clears.
  - Resync never interrupts REQ or DATA.
- When undefined: the port is absent, and address wrap relies solely on the pixel counter.

Decomposition:
- Shared package: FSM state typedef (IDLE, CHECK, REQ, DATA), FRAME_PIXELS = H_RES*V_RES, and the FIFO depth constant 64.
- One natural sub-module: vsync_edge_sync (2-flop synchronizer plus falling-edge detect), instantiated only under FETCH_VSYNC_RESYNC_EN.

Test Plan:
- enable=1, freeslots=64, controller acks after 3 cycles and returns 8 beats 0x000000..0x000007 -> rd_addr=0 on request; 8 consecutive wr_en with data_bgr 0..7, each 1 cycle after its rd_valid; next request at rd_addr=8.
- freeslots=9 (< 8+2) -> rd_req stays 0 indefinitely; raising freeslots to 10 -> rd_req=1 on the next cycle.
- Run a full frame with H_RES=16, V_RES=2, BURST_LEN=8 -> 4 bursts at addresses 0, 8, 16, 24; frame_done pulses once after the 4th; the 5th request is at address 0.
- rd_valid pulsed while in CHECK -> no wr_en; overrun=1 and stays high until reset.
- Assert reset low during DATA beat 4 -> all outputs at reset values asynchronously; after release with enable=1, the first request is at BASE_ADDR.
- With FETCH_VSYNC_RESYNC_EN, vga_vs falls during burst 2 -> burst 2 completes, and the next request is at BASE_ADDR with no frame_done pulse.
